countdown_ctrl: RTL and testbench
=================================

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 SHALL have parameter N, default 6: countdown width in bits (N >= 2).
REQ-002 SHALL have parameter DIV, default 1: clock cycles per decrement (DIV >= 1).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  start, resume or restart request, sampled per cycle.
REQ-006 SHALL have port pause  input  1  pause request, sampled per cycle.
REQ-007 SHALL have port clear  input  1  abort to IDLE, sampled per cycle.
REQ-008 SHALL have port load_en  input  1  load load_val; accepted in IDLE only.
REQ-009 SHALL have port load_val  input  N  value to count down from.
REQ-010 SHALL have port countdownOut  output  N  current count, registered.
REQ-011 SHALL have port state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-012 SHALL have port busy  output  1  high iff state==RUN.
REQ-013 SHALL have port expired  output  1  high iff state==DONE.
REQ-014 SHALL have port done  output  1  one-cycle registered pulse on expiry.

Function
REQ-015 SHALL hold internal registers last_load (N bits) and prescaler (0..DIV-1).
REQ-016 SHALL apply input priority clear > pause > start > load_en, except as stated in REQ-018.
REQ-017 In IDLE, load_en alone SHALL set countdownOut and last_load to load_val; state stays IDLE.
REQ-018 In IDLE, start with load_en in the same cycle SHALL load load_val and enter RUN in the same edge if load_val != 0.
REQ-019 In IDLE, start with an effective count of 0 SHALL be ignored: state stays IDLE, done stays 0.
REQ-020 On entry to RUN from IDLE or DONE, prescaler SHALL be 0.
REQ-021 In RUN, prescaler SHALL increment each cycle; when it equals DIV-1 it SHALL wrap to 0 and countdownOut SHALL decrement by 1 on that edge.
REQ-022 With DIV=1, countdownOut SHALL decrement on every edge in RUN: value L reaches 0 L edges after the start edge.
REQ-023 The decrement taking countdownOut from 1 to 0 SHALL also move the state to DONE and set done=1 for exactly that one cycle.
REQ-024 countdownOut SHALL never wrap below 0.
REQ-025 In RUN, pause SHALL enter PAUSE; countdownOut and prescaler SHALL be frozen, and no decrement SHALL occur on that edge.
REQ-026 In PAUSE, start without pause SHALL return to RUN, with prescaler resuming from its frozen value.
REQ-027 In PAUSE, pause held high SHALL keep PAUSE.
REQ-028 In DONE, countdownOut SHALL hold 0.
REQ-029 In DONE, start SHALL reload countdownOut from last_load and enter RUN if last_load != 0; otherwise it SHALL stay in DONE.
REQ-030 clear in RUN, PAUSE or DONE SHALL enter IDLE with countdownOut = last_load and prescaler = 0; clear in IDLE SHALL do the same.
REQ-031 load_en outside IDLE SHALL be ignored; last_load SHALL be unchanged.
REQ-032 pause in IDLE or DONE SHALL be ignored.
REQ-033 done SHALL be 0 in every cycle other than the cycle described in REQ-023.

Reset
REQ-034 reset low SHALL, asynchronously, set state=IDLE, countdownOut=2^N-1, last_load=2^N-1, prescaler=0, done=0.
REQ-035 busy and expired SHALL be 0 during reset.
REQ-036 reset asserted mid-RUN or mid-PAUSE SHALL take effect immediately, without waiting for a clock edge.
REQ-037 After reset is released, the first clock edge SHALL be evaluated from IDLE.

Verification
REQ-038 Reset, N=6: drive reset=0 -> countdownOut=63, state=0, busy=0, expired=0, done=0, all without a clock edge.
REQ-039 N=6, DIV=1: load_en=1, load_val=5, start=1 in one cycle -> RUN; countdownOut 4,3,2,1,0 on the next 5 edges; done=1 only on the edge reaching 0; state=3 from then on.
REQ-040 DIV=4: start from 3 -> decrements every 4th edge; 0 reached 12 edges after start.
REQ-041 DIV=4: pause at prescaler phase 2 for 5 cycles -> countdownOut and phase frozen; after start, next decrement 2 edges later.
REQ-042 In DONE with last_load=5: pulse start -> countdownOut=5, state=RUN.
REQ-043 clear during RUN -> countdownOut=5, state=IDLE; start with load_val=0 and load_en=1 -> stays IDLE, countdownOut=0, done=0.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Loadable down-counter with a clock prescaler and a four-state run/pause/done controller.
// The count holds at 0 in DONE and can be restarted from the last loaded value.
module countdown_ctrl #(
   parameter int N   = 6,
   parameter int DIV = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         pause,
   input  logic         clear,
   input  logic         load_en,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] countdownOut,
   output logic [1:0]   state,
   output logic         busy,
   output logic         expired,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   // The prescaler needs at least one bit even when DIV=1 (it then stays at 0).
   localparam int            PW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PS_MAX = PW'(DIV - 1);
   localparam logic [N-1:0]  ONE    = N'(1);
   localparam logic [N-1:0]  ZERO   = '0;

   state_e        state_q, state_d;
   logic [N-1:0]  cnt_q, cnt_d;
   logic [N-1:0]  last_q, last_d;
   logic [PW-1:0] ps_q, ps_d;
   logic          done_q, done_d;
   logic          tick;

   assign tick = (ps_q == PS_MAX);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      ps_d    = ps_q;
      done_d  = 1'b0;

      if (clear) begin
         state_d = IDLE;
         cnt_d   = last_q;
         ps_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               // pause has no meaning here, so start/load_en are evaluated as usual.
               if (start && load_en) begin
                  cnt_d  = load_val;
                  last_d = load_val;
                  if (load_val != ZERO) begin
                     state_d = RUN;
                     ps_d    = '0;
                  end
               end else if (start) begin
                  if (cnt_q != ZERO) begin
                     state_d = RUN;
                     ps_d    = '0;
                  end
               end else if (load_en) begin
                  cnt_d  = load_val;
                  last_d = load_val;
               end
            end

            RUN: begin
               if (pause) begin
                  state_d = PAUSE;
               end else if (tick) begin
                  ps_d = '0;
                  if (cnt_q == ONE) begin
                     cnt_d   = ZERO;
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else if (cnt_q == ZERO) begin
                     state_d = DONE;
                  end else begin
                     cnt_d = cnt_q - ONE;
                  end
               end else begin
                  ps_d = ps_q + 1'b1;
               end
            end

            PAUSE: begin
               // Resume keeps the frozen prescaler phase.
               if (!pause && start) state_d = RUN;
            end

            DONE: begin
               cnt_d = ZERO;
               if (start && last_q != ZERO) begin
                  cnt_d   = last_q;
                  state_d = RUN;
                  ps_d    = '0;
               end
            end

            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '1;
         last_q  <= '1;
         ps_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         ps_q    <= ps_d;
         done_q  <= done_d;
      end
   end

   assign countdownOut = cnt_q;
   assign state        = state_q;
   assign busy         = (state_q == RUN);
   assign expired      = (state_q == DONE);
   assign done         = done_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: a DIV=1 and a DIV=4 instance share stimulus and are
// compared every cycle against a plain-arithmetic model, plus literal spot checks.
module tb_countdown_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0, pause = 1'b0, clear = 1'b0, load_en = 1'b0;
   logic [5:0] load_val = '0;
   logic [5:0] cnt_a, cnt_b;
   logic [1:0] st_a, st_b;
   logic       busy_a, busy_b, exp_a, exp_b, done_a, done_b;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   countdown_ctrl #(.N(6), .DIV(1)) u_a (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
      .load_en(load_en), .load_val(load_val), .countdownOut(cnt_a), .state(st_a),
      .busy(busy_a), .expired(exp_a), .done(done_a));

   countdown_ctrl #(.N(6), .DIV(4)) u_b (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
      .load_en(load_en), .load_val(load_val), .countdownOut(cnt_b), .state(st_b),
      .busy(busy_b), .expired(exp_b), .done(done_b));

   // Model: state 0=idle 1=run 2=pause 3=done; phase counts edges within one decrement period.
   int m_st[2]   = '{0, 0};
   int m_cnt[2]  = '{63, 63};
   int m_last[2] = '{63, 63};
   int m_ph[2]   = '{0, 0};
   int m_done[2] = '{0, 0};

   function automatic int div_of(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   task automatic model_step(input int i);
      m_done[i] = 0;
      if (clear) begin
         m_st[i] = 0; m_cnt[i] = m_last[i]; m_ph[i] = 0;
      end else if (m_st[i] == 0) begin
         if (start && load_en) begin
            m_cnt[i] = load_val; m_last[i] = load_val;
            if (load_val != 0) begin m_st[i] = 1; m_ph[i] = 0; end
         end else if (start) begin
            if (m_cnt[i] != 0) begin m_st[i] = 1; m_ph[i] = 0; end
         end else if (load_en) begin
            m_cnt[i] = load_val; m_last[i] = load_val;
         end
      end else if (m_st[i] == 1) begin
         if (pause) m_st[i] = 2;
         else begin
            m_ph[i] = (m_ph[i] + 1) % div_of(i);
            if (m_ph[i] == 0 && m_cnt[i] > 0) begin
               m_cnt[i] = m_cnt[i] - 1;
               if (m_cnt[i] == 0) begin m_st[i] = 3; m_done[i] = 1; end
            end
         end
      end else if (m_st[i] == 2) begin
         if (!pause && start) m_st[i] = 1;
      end else begin
         if (start && m_last[i] != 0) begin
            m_cnt[i] = m_last[i]; m_st[i] = 1; m_ph[i] = 0;
         end
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cnt[i] = 63; m_last[i] = 63; m_ph[i] = 0; m_done[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      chk("a_cnt", cnt_a, m_cnt[0]);
      chk("a_state", st_a, m_st[0]);
      chk("a_busy", busy_a, (m_st[0] == 1) ? 1 : 0);
      chk("a_expired", exp_a, (m_st[0] == 3) ? 1 : 0);
      chk("a_done", done_a, m_done[0]);
      chk("b_cnt", cnt_b, m_cnt[1]);
      chk("b_state", st_b, m_st[1]);
      chk("b_busy", busy_b, (m_st[1] == 1) ? 1 : 0);
      chk("b_expired", exp_b, (m_st[1] == 3) ? 1 : 0);
      chk("b_done", done_b, m_done[1]);
   end

   // Drive inputs just after a falling edge, return just after the next rising edge.
   task automatic step(input logic s, input logic p, input logic c, input logic le,
                       input logic [5:0] lv);
      @(negedge clk);
      #1;
      start = s; pause = p; clear = c; load_en = le; load_val = lv;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 6'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset applied before any clock edge.
      #1 reset = 1'b0;
      #2;
      chk("rst_cnt", cnt_a, 63);
      chk("rst_state", st_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_expired", exp_a, 0);
      chk("rst_done", done_a, 0);
      @(negedge clk);
      #1 reset = 1'b1;

      // Load 5 and start together, DIV=1.
      step(1, 0, 0, 1, 6'd5);
      chk("ls_state", st_a, 1);
      chk("ls_cnt", cnt_a, 5);
      for (int k = 1; k <= 5; k++) begin
         idle(1);
         chk("dec_cnt", cnt_a, 5 - k);
         chk("dec_done", done_a, (k == 5) ? 1 : 0);
         chk("dec_state", st_a, (k == 5) ? 3 : 1);
      end
      idle(1);
      chk("done_pulse_end", done_a, 0);
      chk("done_hold", cnt_a, 0);

      // Restart from DONE using last_load, then clear mid-run.
      step(1, 0, 0, 0, 6'd0);
      chk("restart_cnt", cnt_a, 5);
      chk("restart_state", st_a, 1);
      idle(2);
      step(0, 0, 1, 0, 6'd0);
      chk("clear_cnt", cnt_a, 5);
      chk("clear_state", st_a, 0);
      step(1, 0, 0, 1, 6'd0);
      chk("zero_state", st_a, 0);
      chk("zero_cnt", cnt_a, 0);
      chk("zero_done", done_a, 0);

      // DIV=4 from 3: zero reached 12 edges after the start edge.
      step(1, 0, 0, 1, 6'd3);
      chk("d4_start", st_b, 1);
      n = 0;
      while (cnt_b != 0 && n < 20) begin
         idle(1);
         n++;
      end
      chk("d4_edges", n, 12);
      chk("d4_state", st_b, 3);

      // DIV=4 pause at phase 2 for 5 cycles, then resume.
      step(0, 0, 1, 0, 6'd0);
      step(1, 0, 0, 1, 6'd3);
      idle(2);
      for (int k = 0; k < 5; k++) begin
         step(0, 1, 0, 0, 6'd0);
         chk("pz_cnt", cnt_b, 3);
         chk("pz_state", st_b, 2);
      end
      step(1, 0, 0, 0, 6'd0);
      chk("resume_state", st_b, 1);
      idle(1);
      chk("resume_e1", cnt_b, 3);
      idle(1);
      chk("resume_e2", cnt_b, 2);

      // Asynchronous reset in RUN, visible before the next edge.
      #1 reset = 1'b0;
      #1;
      chk("arst_run_cnt", cnt_b, 63);
      chk("arst_run_state", st_b, 0);
      chk("arst_run_busy", busy_b, 0);
      @(negedge clk);
      #1 reset = 1'b1;

      // Asynchronous reset in PAUSE.
      step(1, 0, 0, 1, 6'd9);
      step(0, 1, 0, 0, 6'd0);
      chk("pause_state", st_b, 2);
      #1 reset = 1'b0;
      #1;
      chk("arst_pause_cnt", cnt_b, 63);
      chk("arst_pause_state", st_b, 0);
      @(negedge clk);
      #1 reset = 1'b1;

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 99) == 0) begin
            @(negedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            #1 reset = 1'b1;
         end else begin
            logic s, p, c, le;
            logic [5:0] lv;
            s  = ($urandom_range(0, 99) < 25);
            p  = ($urandom_range(0, 99) < 15);
            c  = ($urandom_range(0, 99) < 3);
            le = ($urandom_range(0, 99) < 20);
            lv = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : 6'($urandom_range(0, 4));
            step(s, p, c, le, lv);
         end
      end

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
